pdm_deserializer: RTL and testbench
===================================

Name: pdm_deserializer

Overview:
- Receive side of the recorder audio path: drives the PDM microphone clock and samples the 1-bit mic data stream.
- Packs each group of 16 consecutive bits MSB-first into a word, so the first bit received lands in data_o[15]. This is the same bit order the playback serializer transmits.
- Presents each completed word to the memory writer through a valid/ready handshake.
- Flags a sticky overrun when a completed word cannot be delivered.

Parameters:
- CLK_DIV, 25, system clocks per half-period of pdm_clk_o; mic clock = 100 MHz / (2*CLK_DIV) = 2 MHz at default; legal range >= 4.
- WORD_W, 16, bits packed per output word.

Ports:
- clock_i  input  1  100 MHz system clock; all logic on posedge.
- reset_n_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  1 = run mic clock and capture; 0 = idle and discard any partial word.
- pdm_data_i  input  1  mic data (pin H5); asynchronous to clock_i.
- pdm_clk_o  output  1  mic clock (pin J5).
- pdm_lrsel_o  output  1  mic L/R select (pin F5); constant 0 (data valid on mic clock high phase).
- data_o  output  WORD_W  most recent completed word.
- valid_o  output  1  data_o holds an unaccepted word.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i at a posedge.
- overrun_o  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (reset_n_i=0, asynchronous): pdm_clk_o=0, data_o=0, valid_o=0, overrun_o=0, pdm_lrsel_o=0. Divider, bit counter, shift register and synchronizer are cleared; state=IDLE.
- Input sync: pdm_data_i passes through a 2-flop synchronizer. Sampling uses only the second stage (sync2).
- FSM IDLE: pdm_clk_o held 0; div_cnt=0, bit_cnt=0.
  - enable_i=1 -> RUN on next posedge.
- FSM RUN, clock divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and pdm_clk_o toggles. The first toggle (0->1) happens CLK_DIV cycles after entering RUN.
- FSM RUN, sample event: the posedge at which pdm_clk_o toggles 1->0, i.e. end of the high phase.
  - shreg <= {shreg[WORD_W-2:0], sync2}.
  - bit_cnt increments.
- FSM RUN, word complete: the sample event with bit_cnt==WORD_W-1.
  - Word = {shreg[WORD_W-2:0], sync2}; bit_cnt wraps to 0.
  - If valid_o==0, or ready_i==1 in that same cycle: data_o <= word, valid_o <= 1 on that posedge. valid_o is high the cycle after the final sample.
  - Otherwise the new word is dropped, data_o/valid_o are unchanged, and overrun_o <= 1.
- FSM RUN, enable_i=0: -> IDLE on next posedge.
  - pdm_clk_o forced 0; div_cnt, bit_cnt and shreg cleared; partial word discarded.
  - overrun_o cleared.
  - data_o/valid_o are kept until accepted.
- Handshake rules:
  - valid_o && ready_i at a posedge -> valid_o <= 0, unless a word completes in the same cycle, in which case valid_o stays 1 with the new data.
  - data_o is stable while valid_o=1 and not accepted.
  - ready_i is ignored while valid_o=0.
- Throughput: one word per 2*CLK_DIV*WORD_W clocks (800 at defaults).
- enable_i toggling mid-word: the next word starts fresh at bit 0 after re-entry to RUN; no stale bits are mixed in.

Test Plan:
- Reset mid-RUN (CLK_DIV=4): assert reset_n_i with no clock edge -> all outputs 0 immediately. Release with enable_i=1 -> first pdm_clk_o rise 4 cycles after RUN entry; period 8 clocks.
- Pattern capture (CLK_DIV=4, ready_i=1): bench drives bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on pdm_clk_o rising edges -> data_o=16'hA5C3; valid_o high one cycle after the 16th falling edge, one cycle wide.
- Backpressure/overrun (ready_i=0): stream 16'h1234 then 16'hFFFF -> data_o stays 16'h1234, valid_o stays 1, overrun_o=1 after the 32nd sample. Raise ready_i -> valid_o drops; overrun_o remains 1.
- Simultaneous accept and complete: hold valid_o=1 with 16'h00FF; pulse ready_i in the exact cycle the next word 16'hFF00 completes -> data_o=16'hFF00, valid_o stays 1, overrun_o=0.
- Enable drop mid-word: deassert enable_i after 7 bits, re-enable, stream 16'hBEEF -> pdm_clk_o=0 while idle; next data_o=16'hBEEF; overrun_o cleared.
- Continuous streaming at default CLK_DIV=25 with ready_i=1: 8 random words -> data_o matches each word in order; valid_o pulses exactly 800 clocks apart; pdm_lrsel_o=0 throughout.

Source files
------------

// File: rtl/pdm_deserializer.sv
// PDM microphone receiver: generates the mic clock, samples the 1-bit stream at the end
// of each high phase and packs WORD_W bits MSB-first into words behind a valid/ready handshake.
module pdm_deserializer #(
    parameter int CLK_DIV = 25,
    parameter int WORD_W  = 16
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic              pdm_data_i,
    output logic              pdm_clk_o,
    output logic              pdm_lrsel_o,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o
);

    // state | meaning
    // IDLE  | mic clock parked low, counters and partial word cleared
    // RUN   | mic clock toggling, one bit captured per falling edge of pdm_clk_o
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0] shreg_q, shreg_d;
    logic              pdm_clk_q, pdm_clk_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              sync1_q, sync2_q;
    logic [WORD_W-1:0] word;
    logic              complete;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm_data_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            pdm_clk_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            pdm_clk_q <= pdm_clk_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word = {shreg_q, sync2_q};

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        pdm_clk_d = pdm_clk_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                pdm_clk_d = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d   = IDLE;
                    pdm_clk_d = 1'b0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    overrun_d = 1'b0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    pdm_clk_d = ~pdm_clk_q;
                    // Falling edge of the mic clock ends the high phase: data is valid now.
                    if (pdm_clk_q) begin
                        shreg_d = word[WORD_W-2:0];
                        if (bit_cnt_q == BIT_LAST) begin
                            complete  = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // A completed word only lands if the output slot is free or being emptied this cycle.
        if (complete) begin
            if (!valid_q || ready_i) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign pdm_clk_o   = pdm_clk_q;
    assign pdm_lrsel_o = 1'b0;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pdm_deserializer.sv
// Scoreboard bench for pdm_deserializer: a mic model feeds queued bits on pdm_clk_o rises,
// expected words are queued at stimulus time and a negedge monitor pops and compares them.
module tb_pdm_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en0, en1, rdy0, rdy1;
    logic        din0 = 1'b0;
    logic        din1 = 1'b0;
    logic        pclk0, pclk1, lr0, lr1, v0, v1, o0, o1;
    logic [15:0] d0, d1;

    pdm_deserializer #(.CLK_DIV(4), .WORD_W(16)) dut_a (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(en0), .pdm_data_i(din0),
        .pdm_clk_o(pclk0), .pdm_lrsel_o(lr0), .data_o(d0), .valid_o(v0),
        .ready_i(rdy0), .overrun_o(o0)
    );

    pdm_deserializer dut_b (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(en1), .pdm_data_i(din1),
        .pdm_clk_o(pclk1), .pdm_lrsel_o(lr1), .data_o(d1), .valid_o(v1),
        .ready_i(rdy1), .overrun_o(o1)
    );

    int          checks = 0;
    int          errors = 0;
    bit          mic0[$];
    bit          mic1[$];
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    bit          stream_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Mic model: presents the next bit right after each rising edge of its clock.
    always @(posedge pclk0) din0 = (mic0.size() > 0) ? mic0.pop_front() : 1'($urandom_range(0, 1));
    always @(posedge pclk1) din1 = (mic1.size() > 0) ? mic1.pop_front() : 1'($urandom_range(0, 1));

    task automatic push_word(input int g, input logic [15:0] w, input bit expected);
        for (int i = 15; i >= 0; i--) begin
            if (g == 0) mic0.push_back(w[i]);
            else        mic1.push_back(w[i]);
        end
        if (expected) begin
            if (g == 0) exp0.push_back(w);
            else        exp1.push_back(w);
        end
    endtask

    logic        pv[2]   = '{1'b0, 1'b0};
    logic        pacc[2] = '{1'b0, 1'b0};
    logic [15:0] pd[2]   = '{16'h0, 16'h0};
    int          cyc     = 0;
    int          last_t  = -1;

    task automatic mon_step(input int g, input logic v, input logic r, input logic [15:0] d,
                            input logic lr);
        logic [15:0] e;
        if (rst_n === 1'b1) begin
            if (v && (!pv[g] || pacc[g])) begin
                if (g == 0 && exp0.size() > 0) begin
                    e = exp0.pop_front();
                    chk("word_a", 32'(d), 32'(e));
                end else if (g == 1 && exp1.size() > 0) begin
                    e = exp1.pop_front();
                    chk("word_b", 32'(d), 32'(e));
                    chk("lrsel_b", 32'(lr), 0);
                    if (last_t >= 0) chk("spacing_b", cyc - last_t, 800);
                    last_t = cyc;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word_%0d: got %h expected none", g, d);
                end
            end else if (pv[g] && !pacc[g]) begin
                chk("hold", 32'({v, d}), 32'({1'b1, pd[g]}));
            end
        end
        pv[g]   = v;
        pacc[g] = v && r;
        pd[g]   = d;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!stream_on) last_t = -1;
        mon_step(0, v0, rdy0, d0, lr0);
        mon_step(1, v1, rdy1, d1, lr1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_falls(input int n, input int budget, input string nm);
        int   cnt;
        logic prev;
        cnt  = 0;
        prev = pclk0;
        for (int t = 0; t < budget && cnt < n; t++) begin
            @(negedge clk);
            if (prev && !pclk0) cnt++;
            prev = pclk0;
        end
        if (cnt < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d falls expected %0d", nm, cnt, n);
        end
    endtask

    task automatic wait_level(input logic lvl, output int n, input int budget);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pclk0 !== lvl && n < budget);
    endtask

    task automatic wait_empty(input int g, input int budget, input string nm);
        int t;
        for (t = 0; t < budget; t++) begin
            if ((g == 0 ? exp0.size() : exp1.size()) == 0) break;
            @(negedge clk);
        end
        if (t >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", nm,
                     (g == 0 ? exp0.size() : exp1.size()));
        end
    endtask

    initial begin
        int          n;
        logic        hi;
        logic [15:0] w;
        rst_n = 1'b0;
        en0 = 1'b0; en1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b1;
        tick(3);
        chk("reset_a", 32'({pclk0, lr0, v0, o0, d0}), 0);
        chk("reset_b", 32'({pclk1, lr1, v1, o1, d1}), 0);
        rst_n = 1'b1;
        tick(2);

        // Directed pattern capture with valid timing
        rdy0 = 1'b1;
        push_word(0, 16'hA5C3, 1'b1);
        en0 = 1'b1;
        wait_falls(16, 400, "pattern");
        chk("pattern_valid", 32'(v0), 1);
        chk("pattern_data", 32'(d0), 'hA5C3);
        @(negedge clk);
        chk("pattern_pulse", 32'(v0), 0);
        tick(1); en0 = 1'b0; tick(2);

        // Random words, always accepted
        for (int k = 0; k < 4; k++) begin
            w = 16'($urandom);
            push_word(0, w, 1'b1);
        end
        en0 = 1'b1;
        wait_empty(0, 4 * 128 + 100, "rand_a");
        tick(1); en0 = 1'b0; tick(2);

        // Backpressure and overrun
        rdy0 = 1'b0;
        push_word(0, 16'h1234, 1'b1);
        push_word(0, 16'hFFFF, 1'b0);
        en0 = 1'b1;
        wait_falls(31, 600, "bp31");
        chk("bp_no_overrun_yet", 32'(o0), 0);
        wait_falls(1, 40, "bp32");
        chk("bp_valid", 32'(v0), 1);
        chk("bp_data", 32'(d0), 'h1234);
        chk("bp_overrun", 32'(o0), 1);
        tick(1); rdy0 = 1'b1;
        tick(1);
        chk("bp_drain_valid", 32'(v0), 0);
        chk("bp_overrun_sticky", 32'(o0), 1);
        en0 = 1'b0;
        tick(1);
        chk("drop_clears_overrun", 32'(o0), 0);
        chk("drop_clk_low", 32'(pclk0), 0);
        tick(2);

        // Accept and completion in the same cycle
        rdy0 = 1'b0;
        push_word(0, 16'h00FF, 1'b1);
        push_word(0, 16'hFF00, 1'b1);
        en0 = 1'b1;
        wait_falls(31, 600, "sim31");
        chk("sim_hold_valid", 32'(v0), 1);
        chk("sim_hold_data", 32'(d0), 'h00FF);
        repeat (7) @(posedge clk);
        #1 rdy0 = 1'b1;
        @(posedge clk);
        #1 rdy0 = 1'b0;
        chk("sim_valid", 32'(v0), 1);
        chk("sim_data", 32'(d0), 'hFF00);
        chk("sim_overrun", 32'(o0), 0);
        tick(2);

        // Asynchronous reset while running with a held word
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", 32'({pclk0, lr0, v0, o0, d0}), 0);
        mic0.delete();
        exp0.delete();
        tick(2);
        rst_n = 1'b1;
        wait_level(1'b1, n, 50);
        chk("first_rise", n, 6);
        wait_level(1'b0, n, 50);
        chk("high_phase", n, 4);
        wait_level(1'b1, n, 50);
        chk("low_phase", n, 4);
        tick(1); en0 = 1'b0; tick(2);

        // Enable drop mid-word, then a fresh word
        rdy0 = 1'b1;
        for (int k = 0; k < 7; k++) mic0.push_back(1'($urandom_range(0, 1)));
        en0 = 1'b1;
        wait_falls(7, 200, "partial");
        tick(1); en0 = 1'b0;
        hi = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pclk0) hi = 1'b1;
        end
        chk("idle_clk_low", 32'(hi), 0);
        mic0.delete();
        tick(1);
        push_word(0, 16'hBEEF, 1'b1);
        en0 = 1'b1;
        wait_empty(0, 300, "beef");
        chk("beef_data", 32'(d0), 'hBEEF);
        chk("beef_overrun", 32'(o0), 0);
        tick(1); en0 = 1'b0; tick(2);

        // Continuous streaming at the default divider
        stream_on = 1'b1;
        rdy1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = 16'($urandom);
            push_word(1, w, 1'b1);
        end
        en1 = 1'b1;
        wait_empty(1, 8 * 800 + 400, "stream");
        chk("stream_overrun", 32'(o1), 0);
        tick(1); en1 = 1'b0; stream_on = 1'b0; tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
